// File: rtl/decim_sample_uart_tx.sv
// decim_sample_uart_tx: FIFO-buffered 8N1 UART transmitter for decimated filter samples
module decim_sample_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         SAMPLE_IN,
  input  logic               SAMPLE_VALID,
  input  logic               CLR_OVF,
  output logic               TX,
  output logic               BUSY,
  output logic [FIFO_AW:0]   FIFO_LEVEL,
  output logic               OVERFLOW
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = FIFO_AW + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0] mem [2**FIFO_AW];
  logic empty, full, pop, wr, bit_end, tx_n;
  assign FIFO_LEVEL = wr_ptr - rd_ptr;
  assign empty = FIFO_LEVEL == '0;
  assign full = FIFO_LEVEL == PW'(2**FIFO_AW);
  // a pop in the same cycle frees a slot, so a full FIFO still accepts then
  assign wr = SAMPLE_VALID && (!full || pop);
  assign bit_end = timer == T_LAST;
  assign BUSY = state != IDLE;
  always_comb begin
    state_n = state;
    timer_n = bit_end ? '0 : timer + 1'b1;
    idx_n = idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_n = mem[rd_ptr[FIFO_AW-1:0]];
          state_n = START;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n = '0;
      end
      DATA: if (bit_end) begin
        shift_n = {1'b0, shift[7:1]};
        idx_n = idx + 1'b1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (bit_end) begin
        pop = !empty;
        shift_n = empty ? shift : mem[rd_ptr[FIFO_AW-1:0]];
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    // TX is derived from the next state so the registered line lands on the boundary edge
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      TX <= 1'b1;
      OVERFLOW <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx <= idx_n;
      shift <= shift_n;
      wr_ptr <= wr_ptr + PW'(wr);
      rd_ptr <= rd_ptr + PW'(pop);
      TX <= tx_n;
      OVERFLOW <= (SAMPLE_VALID && !wr) ? 1'b1 : CLR_OVF ? 1'b0 : OVERFLOW;
    end
  always_ff @(posedge CLK)
    if (wr) mem[wr_ptr[FIFO_AW-1:0]] <= SAMPLE_IN;
endmodule
